hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage DLX core (IF/ID/EX/MEM/WB).
- Detects load-use and control hazards and generates stall, flush and bubble controls for the IF/ID and ID/EX pipeline registers.
- Registers EX-operand forwarding selects alongside the ID/EX register.
- Freezes the whole pipe while a data-memory access is outstanding, with a timeout watchdog and a stall-cycle performance counter.

Parameters:
MEM_TIMEOUT, 16, max cycles waiting on d_ready before aborting the access (>=2)
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
Rs1_ID  in  5  source 1 of instruction in ID
Rs2_ID  in  5  source 2 of instruction in ID
use_rs1_ID  in  1  ID instruction reads Rs1
use_rs2_ID  in  1  ID instruction reads Rs2
Rd_EX  in  5  destination in EX (0 = no write)
d_load_enable_EX  in  1  EX instruction is a load
Rd_MEM  in  5  destination in MEM (0 = no write)
pc_cmd_EX  in  1  branch taken, resolved in EX
Pc_cmd_id  in  1  jump taken, resolved in ID
d_req_MEM  in  1  load/store active in MEM
d_ready  in  1  data memory completes access this cycle
stall_IF  out  1  hold PC
stall_ID  out  1  hold IF/ID register
flush_ID  out  1  nullify IF/ID register next edge
bubble_EX  out  1  load NOP into ID/EX next edge
freeze  out  1  hold all pipeline registers
fwd_s1_sel_EX  out  2  S1 source in EX: 0 regfile, 1 MEM ALU_out, 2 WB result
fwd_s2_sel_EX  out  2  same for S2
mem_err  out  1  one-cycle pulse on access timeout
stall_count  out  CNT_W  cycles spent in stall or freeze, saturating

Behaviour:
- Reset (async, any state): FSM=RUN; all 1-bit outputs 0; fwd selects 0; stall_count 0; timeout counter 0.
- stall_IF, stall_ID, flush_ID, bubble_EX and freeze are combinational from FSM state and inputs. fwd_*_sel_EX and stall_count are registered.
- Match terms:
  - mEX1 = use_rs1_ID & Rd_EX!=0 & Rd_EX==Rs1_ID; mEX2 likewise for Rs2.
  - mMEM1/mMEM2 likewise against Rd_MEM.
  - Register 0 never matches.
- Forwarding, registered at each non-frozen edge:
  - sel = 1 if mEX and not load; else 2 if mMEM or (mEX & load, after a load-use stall); else 0.
  - EX match has priority over MEM.
  - Forced to 0 when bubble_EX.
  - Held during freeze.
- FSM states:
  - RUN: normal operation.
  - LU_STALL: one-cycle load-use bubble.
  - MEM_WAIT: access outstanding.
- RUN:
  - If d_req_MEM & !d_ready → MEM_WAIT. freeze=1 this cycle; all other controls 0.
  - Else if pc_cmd_EX → flush_ID=1, bubble_EX=1. A load-use condition is ignored because the ID instruction is dead.
  - Else if load-use (d_load_enable_EX & (mEX1|mEX2)) → stall_IF=stall_ID=1, bubble_EX=1, go LU_STALL.
  - Else if Pc_cmd_id → flush_ID=1.
- LU_STALL: lasts exactly one cycle.
  - The load is now in MEM; the held ID instruction re-evaluates with load matching via Rd_MEM (sel=2 next).
  - Returns to RUN; the RUN rules apply in this same cycle.
  - A d_req_MEM miss in this cycle → MEM_WAIT.
- MEM_WAIT:
  - freeze=1; all other controls 0; pc_cmd_EX/Pc_cmd_id deferred because the frozen stages hold them stable.
  - Timeout counter increments each cycle.
  - d_ready=1 → RUN. freeze=0 in that cycle; deferred flushes apply in that cycle.
  - Counter reaches MEM_TIMEOUT-1 without d_ready → mem_err pulses 1, access abandoned, RUN next cycle, counter cleared.
  - d_ready and timeout in the same cycle: d_ready wins, no mem_err.
- stall_count:
  - +1 per cycle where freeze | stall_ID.
  - Saturates at all-ones, no wrap.
- Simultaneous pc_cmd_EX and Pc_cmd_id: pc_cmd_EX wins; a single flush covers both.

Decomposition:
- Package dlx_pipe_pkg:
  - ctrl_state_t enum {RUN, LU_STALL, MEM_WAIT}
  - fwd_sel_t enum {FWD_RF=0, FWD_MEM=1, FWD_WB=2}
  - REG_ZERO constant
- One sub-module fwd_unit: combinational match logic and selection for one operand, instantiated twice; hazard_ctrl owns the registers.

Test Plan:
- Load-use:
  - Stimulus: d_load_enable_EX=1, Rd_EX=3, Rs1_ID=3, use_rs1_ID=1.
  - Response: one cycle of stall_IF=stall_ID=bubble_EX=1. Next edge fwd_s1_sel_EX=2. stall_count=1.
- ALU forwarding and r0:
  - Stimulus: Rd_EX=5, non-load, Rs2_ID=5.
  - Response: fwd_s2_sel_EX=1 after the edge. Repeat with Rd_EX=0, Rs2_ID=0 → sel 0, no stall.
- Branch beats load-use:
  - Stimulus: load-use condition plus pc_cmd_EX=1.
  - Response: flush_ID=bubble_EX=1, stall_ID=0, FSM stays RUN.
- Memory wait:
  - Stimulus: d_req_MEM=1, d_ready low 3 cycles then high, Pc_cmd_id=1 throughout.
  - Response: freeze=1 for 3 cycles, then flush_ID=1 on the d_ready cycle. stall_count +3.
- Timeout:
  - Stimulus: d_req_MEM=1, d_ready never asserted.
  - Response: mem_err=1 exactly in cycle 16 of the wait, freeze=0 the next cycle.
- Reset mid-wait:
  - Stimulus: reset_n low asynchronously during MEM_WAIT.
  - Response: freeze drops immediately; all outputs 0, stall_count 0, FSM RUN after release.

Source files
------------

// File: rtl/dlx_pipe_pkg.sv
// Shared types for the DLX pipeline sequencer: controller states, forwarding selects.
// Pure declarations, no logic.
package dlx_pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } ctrl_state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/fwd_unit.sv
// Operand match and forwarding-source selection for one EX source operand.
// Purely combinational; the parent registers the result.
module fwd_unit
    import dlx_pipe_pkg::*;
(
    input  logic [4:0] rs,
    input  logic       use_rs,
    input  logic [4:0] rd_ex,
    input  logic       load_ex,
    input  logic [4:0] rd_mem,
    output logic       m_ex,
    output fwd_sel_t   sel
);

    logic m_mem;

    assign m_ex  = use_rs && (rd_ex  != REG_ZERO) && (rd_ex  == rs);
    assign m_mem = use_rs && (rd_mem != REG_ZERO) && (rd_mem == rs);

    // A load in EX only reaches this register after its bubble, by which time it sits in WB.
    always_comb begin
        sel = FWD_RF;
        if (m_ex) begin
            sel = load_ex ? FWD_WB : FWD_MEM;
        end else if (m_mem) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// DLX pipeline sequencer: load-use/control hazard stalls, flushes, bubbles and EX forwarding selects.
// Controls are combinational; forwarding selects and stall counter are registered; data-memory waits freeze the whole pipe.
module hazard_ctrl
    import dlx_pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       Rs1_ID,
    input  logic [4:0]       Rs2_ID,
    input  logic             use_rs1_ID,
    input  logic             use_rs2_ID,
    input  logic [4:0]       Rd_EX,
    input  logic             d_load_enable_EX,
    input  logic [4:0]       Rd_MEM,
    input  logic             pc_cmd_EX,
    input  logic             Pc_cmd_id,
    input  logic             d_req_MEM,
    input  logic             d_ready,
    output logic             stall_IF,
    output logic             stall_ID,
    output logic             flush_ID,
    output logic             bubble_EX,
    output logic             freeze,
    output logic [1:0]       fwd_s1_sel_EX,
    output logic [1:0]       fwd_s2_sel_EX,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_count
);

    localparam int             TMO_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    ctrl_state_t      state_q, state_d;
    logic [TMO_W-1:0] tmo_q;
    logic             abandon_q;
    fwd_sel_t         fwd_s1_q, fwd_s2_q;
    logic [CNT_W-1:0] cnt_q;

    fwd_sel_t sel1, sel2;
    logic     m_ex1, m_ex2;
    logic     load_use, mem_miss, run_rules;
    logic     stall_if_c, stall_id_c, flush_id_c, bubble_ex_c, freeze_c, mem_err_c;

    fwd_unit u_fwd_s1 (
        .rs      (Rs1_ID),
        .use_rs  (use_rs1_ID),
        .rd_ex   (Rd_EX),
        .load_ex (d_load_enable_EX),
        .rd_mem  (Rd_MEM),
        .m_ex    (m_ex1),
        .sel     (sel1)
    );

    fwd_unit u_fwd_s2 (
        .rs      (Rs2_ID),
        .use_rs  (use_rs2_ID),
        .rd_ex   (Rd_EX),
        .load_ex (d_load_enable_EX),
        .rd_mem  (Rd_MEM),
        .m_ex    (m_ex2),
        .sel     (sel2)
    );

    assign load_use = d_load_enable_EX && (m_ex1 || m_ex2);
    // The access that just timed out is still presented for one cycle while the pipe drains past it.
    assign mem_miss = d_req_MEM && !d_ready && !abandon_q;

    always_comb begin
        state_d     = state_q;
        stall_if_c  = 1'b0;
        stall_id_c  = 1'b0;
        flush_id_c  = 1'b0;
        bubble_ex_c = 1'b0;
        freeze_c    = 1'b0;
        mem_err_c   = 1'b0;
        run_rules   = 1'b0;

        case (state_q)
            MEM_WAIT: begin
                if (!d_ready) begin
                    freeze_c = 1'b1;
                    if (tmo_q == TMO_LAST) begin
                        mem_err_c = 1'b1;
                        state_d   = RUN;
                    end
                end else begin
                    run_rules = 1'b1;
                end
            end
            default: run_rules = 1'b1;
        endcase

        if (run_rules) begin
            state_d = RUN;
            if (mem_miss) begin
                freeze_c = 1'b1;
                state_d  = MEM_WAIT;
            end else if (pc_cmd_EX) begin
                flush_id_c  = 1'b1;
                bubble_ex_c = 1'b1;
            end else if (load_use && (state_q != LU_STALL)) begin
                stall_if_c  = 1'b1;
                stall_id_c  = 1'b1;
                bubble_ex_c = 1'b1;
                state_d     = LU_STALL;
            end else if (Pc_cmd_id) begin
                flush_id_c = 1'b1;
            end
        end
    end

    // Reset forces controls low immediately, even while the memory request is still asserted.
    assign stall_IF      = stall_if_c  & reset_n;
    assign stall_ID      = stall_id_c  & reset_n;
    assign flush_ID      = flush_id_c  & reset_n;
    assign bubble_EX     = bubble_ex_c & reset_n;
    assign freeze        = freeze_c    & reset_n;
    assign mem_err       = mem_err_c   & reset_n;
    assign fwd_s1_sel_EX = fwd_s1_q;
    assign fwd_s2_sel_EX = fwd_s2_q;
    assign stall_count   = cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RUN;
            tmo_q     <= '0;
            abandon_q <= 1'b0;
            fwd_s1_q  <= FWD_RF;
            fwd_s2_q  <= FWD_RF;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            abandon_q <= mem_err_c;
            if ((state_q == MEM_WAIT) && (state_d == MEM_WAIT)) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end else begin
                tmo_q <= '0;
            end
            if (!freeze_c) begin
                fwd_s1_q <= bubble_ex_c ? FWD_RF : sel1;
                fwd_s2_q <= bubble_ex_c ? FWD_RF : sel2;
            end
            if ((freeze_c || stall_id_c) && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; counter narrowed to 4 bits so saturation is reachable.
module tb_hazard_ctrl;

    logic       clk;
    logic       reset_n;
    logic [4:0] Rs1_ID, Rs2_ID, Rd_EX, Rd_MEM;
    logic       use_rs1_ID, use_rs2_ID, d_load_enable_EX;
    logic       pc_cmd_EX, Pc_cmd_id, d_req_MEM, d_ready;
    logic       stall_IF, stall_ID, flush_ID, bubble_EX, freeze, mem_err;
    logic [1:0] fwd_s1_sel_EX, fwd_s2_sel_EX;
    logic [3:0] stall_count;
    logic [5:0] ctrl;

    int vectors    = 0;
    int miscompares = 0;

    // {stall_IF, stall_ID, flush_ID, bubble_EX, freeze, mem_err}
    assign ctrl = {stall_IF, stall_ID, flush_ID, bubble_EX, freeze, mem_err};

    hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .Rs1_ID           (Rs1_ID),
        .Rs2_ID           (Rs2_ID),
        .use_rs1_ID       (use_rs1_ID),
        .use_rs2_ID       (use_rs2_ID),
        .Rd_EX            (Rd_EX),
        .d_load_enable_EX (d_load_enable_EX),
        .Rd_MEM           (Rd_MEM),
        .pc_cmd_EX        (pc_cmd_EX),
        .Pc_cmd_id        (Pc_cmd_id),
        .d_req_MEM        (d_req_MEM),
        .d_ready          (d_ready),
        .stall_IF         (stall_IF),
        .stall_ID         (stall_ID),
        .flush_ID         (flush_ID),
        .bubble_EX        (bubble_EX),
        .freeze           (freeze),
        .fwd_s1_sel_EX    (fwd_s1_sel_EX),
        .fwd_s2_sel_EX    (fwd_s2_sel_EX),
        .mem_err          (mem_err),
        .stall_count      (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        Rs1_ID = 5'd0; Rs2_ID = 5'd0; Rd_EX = 5'd0; Rd_MEM = 5'd0;
        use_rs1_ID = 1'b0; use_rs2_ID = 1'b0; d_load_enable_EX = 1'b0;
        pc_cmd_EX = 1'b0; Pc_cmd_id = 1'b0; d_req_MEM = 1'b0; d_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        tick();
        tick();
        vectors++;
        if (ctrl !== 6'b000000) begin miscompares++; $display("FAIL reset_ctrl: got %b want 000000", ctrl); end
        vectors++;
        if ({fwd_s1_sel_EX, fwd_s2_sel_EX} !== 4'b0000) begin miscompares++; $display("FAIL reset_fwd: got %b want 0000", {fwd_s1_sel_EX, fwd_s2_sel_EX}); end
        vectors++;
        if (stall_count !== 4'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", stall_count); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        idle();
        d_load_enable_EX = 1'b1; Rd_EX = 5'd3; Rs1_ID = 5'd3; use_rs1_ID = 1'b1;
        #1;
        vectors++;
        if (ctrl !== 6'b110100) begin miscompares++; $display("FAIL lu_ctrl: got %b want 110100", ctrl); end
        tick();
        vectors++;
        if (fwd_s1_sel_EX !== 2'd0) begin miscompares++; $display("FAIL lu_bubble_sel: got %0d want 0", fwd_s1_sel_EX); end
        vectors++;
        if (stall_count !== 4'd1) begin miscompares++; $display("FAIL lu_cnt: got %0d want 1", stall_count); end
        // load has advanced to MEM while ID is held
        d_load_enable_EX = 1'b0; Rd_EX = 5'd0; Rd_MEM = 5'd3;
        #1;
        vectors++;
        if (ctrl !== 6'b000000) begin miscompares++; $display("FAIL lu_second_ctrl: got %b want 000000", ctrl); end
        tick();
        vectors++;
        if (fwd_s1_sel_EX !== 2'd2) begin miscompares++; $display("FAIL lu_wb_sel: got %0d want 2", fwd_s1_sel_EX); end
        vectors++;
        if (stall_count !== 4'd1) begin miscompares++; $display("FAIL lu_cnt_hold: got %0d want 1", stall_count); end
    endtask

    task automatic test_alu_fwd();
        idle();
        Rd_EX = 5'd5; Rs2_ID = 5'd5; use_rs2_ID = 1'b1;
        tick();
        vectors++;
        if ({fwd_s1_sel_EX, fwd_s2_sel_EX} !== 4'b0001) begin miscompares++; $display("FAIL alu_sel: got %b want 0001", {fwd_s1_sel_EX, fwd_s2_sel_EX}); end
        Rd_EX = 5'd0; Rs2_ID = 5'd0; d_load_enable_EX = 1'b1;
        #1;
        vectors++;
        if (ctrl !== 6'b000000) begin miscompares++; $display("FAIL r0_ctrl: got %b want 000000", ctrl); end
        tick();
        vectors++;
        if (fwd_s2_sel_EX !== 2'd0) begin miscompares++; $display("FAIL r0_sel: got %0d want 0", fwd_s2_sel_EX); end
        idle();
        Rd_MEM = 5'd7; Rs1_ID = 5'd7; use_rs1_ID = 1'b1;
        tick();
        vectors++;
        if (fwd_s1_sel_EX !== 2'd2) begin miscompares++; $display("FAIL mem_sel: got %0d want 2", fwd_s1_sel_EX); end
        Rd_EX = 5'd7;
        tick();
        vectors++;
        if (fwd_s1_sel_EX !== 2'd1) begin miscompares++; $display("FAIL ex_priority: got %0d want 1", fwd_s1_sel_EX); end
        use_rs1_ID = 1'b0;
        tick();
        vectors++;
        if (fwd_s1_sel_EX !== 2'd0) begin miscompares++; $display("FAIL unused_rs: got %0d want 0", fwd_s1_sel_EX); end
        vectors++;
        if (stall_count !== 4'd1) begin miscompares++; $display("FAIL alu_cnt: got %0d want 1", stall_count); end
    endtask

    task automatic test_branch_beats_lu();
        idle();
        d_load_enable_EX = 1'b1; Rd_EX = 5'd4; Rs2_ID = 5'd4; use_rs2_ID = 1'b1;
        pc_cmd_EX = 1'b1; Pc_cmd_id = 1'b1;
        #1;
        vectors++;
        if (ctrl !== 6'b001100) begin miscompares++; $display("FAIL br_ctrl: got %b want 001100", ctrl); end
        tick();
        vectors++;
        if (fwd_s2_sel_EX !== 2'd0) begin miscompares++; $display("FAIL br_sel: got %0d want 0", fwd_s2_sel_EX); end
        // still in RUN, so a fresh load-use must stall
        pc_cmd_EX = 1'b0; Pc_cmd_id = 1'b0;
        #1;
        vectors++;
        if (ctrl !== 6'b110100) begin miscompares++; $display("FAIL br_then_lu: got %b want 110100", ctrl); end
        tick();
        idle();
        Pc_cmd_id = 1'b1;
        #1;
        vectors++;
        if (ctrl !== 6'b001000) begin miscompares++; $display("FAIL jump_ctrl: got %b want 001000", ctrl); end
        tick();
        idle();
        tick();
        vectors++;
        if (stall_count !== 4'd2) begin miscompares++; $display("FAIL br_cnt: got %0d want 2", stall_count); end
    endtask

    task automatic test_mem_wait();
        idle();
        d_req_MEM = 1'b1; Pc_cmd_id = 1'b1;
        Rd_EX = 5'd5; Rs1_ID = 5'd5; use_rs1_ID = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if (ctrl !== 6'b000010) begin miscompares++; $display("FAIL wait_ctrl[%0d]: got %b want 000010", c, ctrl); end
            tick();
        end
        vectors++;
        if (fwd_s1_sel_EX !== 2'd0) begin miscompares++; $display("FAIL wait_hold_sel: got %0d want 0", fwd_s1_sel_EX); end
        d_ready = 1'b1;
        #1;
        vectors++;
        if (ctrl !== 6'b001000) begin miscompares++; $display("FAIL ready_ctrl: got %b want 001000", ctrl); end
        tick();
        vectors++;
        if (fwd_s1_sel_EX !== 2'd1) begin miscompares++; $display("FAIL ready_sel: got %0d want 1", fwd_s1_sel_EX); end
        vectors++;
        if (stall_count !== 4'd5) begin miscompares++; $display("FAIL wait_cnt: got %0d want 5", stall_count); end
        idle();
        tick();
    endtask

    task automatic test_timeout();
        logic [5:0] want;
        idle();
        d_req_MEM = 1'b1;
        #1;
        vectors++;
        if (ctrl !== 6'b000010) begin miscompares++; $display("FAIL tmo_enter: got %b want 000010", ctrl); end
        tick();
        for (int k = 1; k <= 16; k++) begin
            want = (k == 16) ? 6'b000011 : 6'b000010;
            #1;
            vectors++;
            if (ctrl !== want) begin miscompares++; $display("FAIL tmo_cycle[%0d]: got %b want %b", k, ctrl, want); end
            tick();
        end
        #1;
        vectors++;
        if (ctrl !== 6'b000000) begin miscompares++; $display("FAIL tmo_release: got %b want 000000", ctrl); end
        idle();
        tick();
        vectors++;
        if (stall_count !== 4'd15) begin miscompares++; $display("FAIL cnt_saturate: got %0d want 15", stall_count); end
    endtask

    task automatic test_reset_mid_wait();
        idle();
        d_req_MEM = 1'b1;
        tick();
        #1;
        vectors++;
        if (ctrl !== 6'b000010) begin miscompares++; $display("FAIL mid_pre: got %b want 000010", ctrl); end
        #1;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (ctrl !== 6'b000000) begin miscompares++; $display("FAIL mid_async: got %b want 000000", ctrl); end
        vectors++;
        if (stall_count !== 4'd0) begin miscompares++; $display("FAIL mid_cnt: got %0d want 0", stall_count); end
        idle();
        tick();
        reset_n = 1'b1;
        #1;
        vectors++;
        if ({ctrl, fwd_s1_sel_EX, fwd_s2_sel_EX} !== 10'd0) begin miscompares++; $display("FAIL mid_release: got %b want 0", {ctrl, fwd_s1_sel_EX, fwd_s2_sel_EX}); end
        d_load_enable_EX = 1'b1; Rd_EX = 5'd9; Rs1_ID = 5'd9; use_rs1_ID = 1'b1;
        #1;
        vectors++;
        if (ctrl !== 6'b110100) begin miscompares++; $display("FAIL mid_run_state: got %b want 110100", ctrl); end
        tick();
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_alu_fwd();
        test_branch_beats_lu();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
